// File: rtl/usb4_rx_pkg.sv
// Shared definitions for the USB4 multi-lane ordered-set receiver.
//   - ordered-set codes carried on d_sel / os_in
//   - Gen3 64-bit training-set bases (lane-number field [55:48] left zero)
//   - Gen4 32-bit training-set constants
//   - lane FSM state type
//   - exp_pattern(): expected value plus compare mask for a d_sel code and lane
package usb4_rx_pkg;

  localparam logic [3:0] OS_NONE   = 4'd0;
  localparam logic [3:0] OS_RSVD1  = 4'd1;
  localparam logic [3:0] OS_G3_TS1 = 4'd2;
  localparam logic [3:0] OS_G3_TS2 = 4'd3;
  localparam logic [3:0] OS_RSVD4  = 4'd4;
  localparam logic [3:0] OS_G4_TS2 = 4'd5;
  localparam logic [3:0] OS_G4_TS3 = 4'd6;
  localparam logic [3:0] OS_G4_TS4 = 4'd7;
  localparam logic [3:0] OS_DATA   = 4'd8;
  localparam logic [3:0] OS_IDLE   = 4'd9;

  localparam logic [63:0] GEN3_TS1 = 64'h0F00_F0F0_1E2D_3C4B;
  localparam logic [63:0] GEN3_TS2 = 64'hF000_0F0F_E1D2_C3B4;

  localparam logic [31:0] GEN4_TS2 = 32'h5A5A_0F2D;
  localparam logic [31:0] GEN4_TS3 = 32'h5A5A_1E3C;
  localparam logic [31:0] GEN4_TS4 = 32'h5A5A_2D4B;

  typedef enum logic [1:0] {
    LANE_OFF,
    LANE_HUNT,
    LANE_COUNT,
    LANE_LOCKED
  } lane_state_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] value;
    logic [63:0] mask;
  } os_pattern_t;

  // Gen3 sets are compared in full with the lane index in [55:48];
  // Gen4 sets only carry a meaningful low 32-bit word.
  function automatic os_pattern_t exp_pattern(input logic [3:0] sel,
                                               input logic [7:0] lane_idx);
    os_pattern_t p;
    p.valid = 1'b0;
    p.value = '0;
    p.mask  = '0;
    case (sel)
      OS_G3_TS1: begin
        p.valid          = 1'b1;
        p.value          = GEN3_TS1;
        p.value[55:48]   = lane_idx;
        p.mask           = '1;
      end
      OS_G3_TS2: begin
        p.valid          = 1'b1;
        p.value          = GEN3_TS2;
        p.value[55:48]   = lane_idx;
        p.mask           = '1;
      end
      OS_G4_TS2: begin
        p.valid = 1'b1;
        p.value = {32'h0, GEN4_TS2};
        p.mask  = {32'h0, 32'hFFFF_FFFF};
      end
      OS_G4_TS3: begin
        p.valid = 1'b1;
        p.value = {32'h0, GEN4_TS3};
        p.mask  = {32'h0, 32'hFFFF_FFFF};
      end
      OS_G4_TS4: begin
        p.valid = 1'b1;
        p.value = {32'h0, GEN4_TS4};
        p.mask  = {32'h0, 32'hFFFF_FFFF};
      end
      default: ;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/lane_os_tracker.sv
// One receive lane: 8-byte framing, registered pattern compare, lock FSM,
// hunt timeout and (with OS_ERR_COUNT_EN defined) a saturating error counter.
// Ports:
//   clk, rst (async, active-low)
//   lane_rx_on  receive enable, low forces OFF
//   d_sel       expected ordered-set code
//   lane_byte   received byte for this lane
//   os_code     d_sel while LOCKED, OS_IDLE otherwise
//   os_valid    one-cycle pulse on LOCKED entry
//   os_locked   lane is LOCKED
//   os_timeout  sticky hunt timeout
//   err_cnt     (OS_ERR_COUNT_EN only) mismatching sets seen in COUNT/LOCKED
module lane_os_tracker
  import usb4_rx_pkg::*;
#(
  parameter int unsigned LANE_IDX       = 0,
  parameter int unsigned MATCH_COUNT    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lane_rx_on,
  input  logic [3:0] d_sel,
  input  logic [7:0] lane_byte,
  output logic [3:0] os_code,
  output logic       os_valid,
  output logic       os_locked,
  output logic       os_timeout
`ifdef OS_ERR_COUNT_EN
  ,
  output logic [7:0] err_cnt
`endif
);

  localparam int unsigned TW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TONE = TW'(1);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [3:0] MC = 4'(MATCH_COUNT);

  lane_state_t state, state_next;
  logic [2:0]    byte_cnt;
  logic [63:0]   sr, sr_next;
  logic          cmp_done, cmp_match;
  os_pattern_t   pat;
  logic [3:0]    d_sel_q;
  logic          d_sel_chg;
  logic          framing;
  logic          hunting;
  logic [3:0]    match_cnt, match_cnt_next;
  logic [TW-1:0] timer, timer_next;
  logic          timeout_next;
  logic [3:0]    code_next;
  logic          valid_next, locked_next;

  assign framing   = lane_rx_on && (state != LANE_OFF);
  assign d_sel_chg = (d_sel != d_sel_q);
  assign sr_next   = {sr[55:0], lane_byte};
  assign pat       = exp_pattern(d_sel, 8'(LANE_IDX));

  // Framing stays parked at zero in OFF, so the OFF->HUNT edge restarts it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_cnt  <= '0;
      sr        <= '0;
      cmp_done  <= 1'b0;
      cmp_match <= 1'b0;
    end else if (!framing) begin
      byte_cnt  <= '0;
      sr        <= '0;
      cmp_done  <= 1'b0;
      cmp_match <= 1'b0;
    end else begin
      byte_cnt  <= byte_cnt + 3'd1;
      sr        <= sr_next;
      cmp_done  <= (byte_cnt == 3'd7);
      cmp_match <= pat.valid && (((sr_next ^ pat.value) & pat.mask) == '0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) d_sel_q <= '0;
    else      d_sel_q <= d_sel;
  end

  // State register (outputs are registered copies of the output comb).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= LANE_OFF;
      match_cnt  <= '0;
      timer      <= '0;
      os_timeout <= 1'b0;
      os_code    <= OS_IDLE;
      os_valid   <= 1'b0;
      os_locked  <= 1'b0;
    end else begin
      state      <= state_next;
      match_cnt  <= match_cnt_next;
      timer      <= timer_next;
      os_timeout <= timeout_next;
      os_code    <= code_next;
      os_valid   <= valid_next;
      os_locked  <= locked_next;
    end
  end

  // Next state. A pending compare result is dropped when d_sel changed,
  // since it was evaluated against the previous code.
  always_comb begin
    state_next     = state;
    match_cnt_next = match_cnt;
    if (!lane_rx_on) begin
      state_next     = LANE_OFF;
      match_cnt_next = '0;
    end else if (state == LANE_OFF) begin
      state_next     = LANE_HUNT;
      match_cnt_next = '0;
    end else if (d_sel_chg) begin
      state_next     = LANE_HUNT;
      match_cnt_next = '0;
    end else if (cmp_done) begin
      case (state)
        LANE_HUNT: begin
          if (cmp_match) begin
            match_cnt_next = 4'd1;
            state_next     = (MC <= 4'd1) ? LANE_LOCKED : LANE_COUNT;
          end
        end
        LANE_COUNT: begin
          if (cmp_match) begin
            match_cnt_next = match_cnt + 4'd1;
            if (match_cnt_next >= MC) state_next = LANE_LOCKED;
          end else begin
            match_cnt_next = '0;
            state_next     = LANE_HUNT;
          end
        end
        LANE_LOCKED: begin
          if (!cmp_match) begin
            match_cnt_next = '0;
            state_next     = LANE_HUNT;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs, timer and timeout flag.
  always_comb begin
    hunting      = (state == LANE_HUNT) || (state == LANE_COUNT);
    timer_next   = '0;
    timeout_next = os_timeout;
    if (lane_rx_on && hunting && !d_sel_chg && (state_next != LANE_LOCKED)) begin
      timer_next = timer;
      if (TO_EN && (timer != TMAX)) timer_next = timer + TONE;
    end
    if (d_sel_chg) begin
      timeout_next = 1'b0;
    end else if (TO_EN && lane_rx_on && hunting && (timer_next == TMAX)) begin
      timeout_next = 1'b1;
    end
    locked_next = (state_next == LANE_LOCKED);
    valid_next  = locked_next && (state != LANE_LOCKED);
    code_next   = locked_next ? d_sel : OS_IDLE;
  end

`ifdef OS_ERR_COUNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt <= '0;
    end else if (!lane_rx_on || (state == LANE_OFF) || d_sel_chg) begin
      err_cnt <= '0;
    end else if (cmp_done && !cmp_match &&
                 ((state == LANE_COUNT) || (state == LANE_LOCKED)) &&
                 (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: rtl/lane_os_receiver.sv
// USB4 logical-layer multi-lane receive front end.
// One lane_os_tracker per lane reports training ordered sets; this level
// also carries the data-mode path to the transport layer.
// Optional build macro: OS_ERR_COUNT_EN adds os_err_cnt (8 bits per lane).
// Ports:
//   clk, rst (async, active-low)
//   lane_rx_on       receive enable
//   d_sel            expected set code (8 = data mode)
//   data_os          data byte qualifier
//   lane_rx          lane i byte at [8i+7:8i]
//   os_in            per-lane reported code or 4'h9 idle
//   os_valid         per-lane lock pulse
//   os_locked        per-lane locked level
//   os_timeout       per-lane sticky timeout
//   transport_data   registered lane bytes, lane 0 in LSBs
//   transport_valid  transport_data qualifier
module lane_os_receiver
  import usb4_rx_pkg::*;
#(
  parameter int unsigned NUM_LANES      = 2,
  parameter int unsigned MATCH_COUNT    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   lane_rx_on,
  input  logic [3:0]             d_sel,
  input  logic                   data_os,
  input  logic [NUM_LANES*8-1:0] lane_rx,
  output logic [NUM_LANES*4-1:0] os_in,
  output logic [NUM_LANES-1:0]   os_valid,
  output logic [NUM_LANES-1:0]   os_locked,
  output logic [NUM_LANES-1:0]   os_timeout,
  output logic [NUM_LANES*8-1:0] transport_data,
  output logic                   transport_valid
`ifdef OS_ERR_COUNT_EN
  ,
  output logic [NUM_LANES*8-1:0] os_err_cnt
`endif
);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lane_os_tracker #(
      .LANE_IDX      (i),
      .MATCH_COUNT   (MATCH_COUNT),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .lane_rx_on(lane_rx_on),
      .d_sel     (d_sel),
      .lane_byte (lane_rx[8*i +: 8]),
      .os_code   (os_in[4*i +: 4]),
      .os_valid  (os_valid[i]),
      .os_locked (os_locked[i]),
      .os_timeout(os_timeout[i])
`ifdef OS_ERR_COUNT_EN
      ,
      .err_cnt   (os_err_cnt[8*i +: 8])
`endif
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      transport_data  <= '0;
      transport_valid <= 1'b0;
    end else if (lane_rx_on && (d_sel == OS_DATA)) begin
      transport_data  <= lane_rx;
      transport_valid <= data_os;
    end else begin
      transport_data  <= '0;
      transport_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lane_os_receiver.sv
// Scoreboard bench for lane_os_receiver (2 lanes, MATCH_COUNT=2,
// TIMEOUT_CYCLES=64). Expected lock pulses and transport words are queued
// by the stimulus; a negedge monitor pops and compares them.
module tb_lane_os_receiver;

  localparam logic [63:0] TS1_BASE = 64'h0F00_F0F0_1E2D_3C4B;
  localparam logic [31:0] G4_TS2   = 32'h5A5A_0F2D;
  localparam logic [31:0] G4_TS3   = 32'h5A5A_1E3C;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        lane_rx_on = 1'b0;
  logic [3:0]  d_sel = 4'd0;
  logic        data_os = 1'b0;
  logic [15:0] lane_rx = 16'h0;
  logic [7:0]  os_in;
  logic [1:0]  os_valid, os_locked, os_timeout;
  logic [15:0] transport_data;
  logic        transport_valid;
`ifdef OS_ERR_COUNT_EN
  logic [15:0] os_err_cnt;
`endif

  lane_os_receiver #(
    .NUM_LANES     (2),
    .MATCH_COUNT   (2),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .lane_rx_on     (lane_rx_on),
    .d_sel          (d_sel),
    .data_os        (data_os),
    .lane_rx        (lane_rx),
    .os_in          (os_in),
    .os_valid       (os_valid),
    .os_locked      (os_locked),
    .os_timeout     (os_timeout),
    .transport_data (transport_data),
    .transport_valid(transport_valid)
`ifdef OS_ERR_COUNT_EN
    ,
    .os_err_cnt     (os_err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int         edge_no;
    logic [1:0] mask;
    logic [7:0] code;
  } os_exp_t;

  typedef struct {
    int          edge_no;
    logic [15:0] data;
  } tr_exp_t;

  os_exp_t os_q[$];
  tr_exp_t tr_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Monitor: every lock pulse and every transport word must be expected.
  always @(negedge clk) begin
    os_exp_t oe;
    tr_exp_t te;
    if (os_valid !== 2'b00) begin
      if (os_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL os_valid_unexpected: got %b expected no pulse (edge %0d)", os_valid, edge_n);
      end else begin
        oe = os_q.pop_front();
        check("os_valid_edge", edge_n, oe.edge_no);
        check("os_valid_mask", 32'(os_valid), 32'(oe.mask));
        check("os_in_at_valid", 32'(os_in), 32'(oe.code));
      end
    end
    if (transport_valid !== 1'b0) begin
      if (tr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL transport_unexpected: got %h expected no word (edge %0d)", transport_data, edge_n);
      end else begin
        te = tr_q.pop_front();
        check("transport_edge", edge_n, te.edge_no);
        check("transport_data", 32'(transport_data), 32'(te.data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b0, input logic [7:0] b1);
    lane_rx = {b1, b0};
    tick();
  endtask

  // Most significant byte goes first so it ends up in sr[63:56].
  task automatic send_set(input logic [63:0] p0, input logic [63:0] p1);
    for (int k = 7; k >= 0; k--) send_byte(p0[8*k +: 8], p1[8*k +: 8]);
  endtask

  task automatic go_off();
    lane_rx_on = 1'b0;
    tick();
    check("off_locked", 32'(os_locked), 32'h0);
    check("off_os_in", 32'(os_in), 32'h99);
  endtask

  function automatic logic [63:0] g3(input logic [63:0] base, input logic [7:0] lane);
    logic [63:0] v;
    v = base;
    v[55:48] = lane;
    return v;
  endfunction

  initial begin
    logic [63:0] good, good2, bad, ts3;
    #2 rst = 1'b0;
    #1;
    check("rst_os_in", 32'(os_in), 32'h99);
    check("rst_os_valid", 32'(os_valid), 32'h0);
    check("rst_os_locked", 32'(os_locked), 32'h0);
    check("rst_os_timeout", 32'(os_timeout), 32'h0);
    check("rst_tdata", 32'(transport_data), 32'h0);
    check("rst_tvalid", 32'(transport_valid), 32'h0);
    tick();
    rst = 1'b1;
    tick();

    // Gen3 TS1, correct lane ids on both lanes.
    d_sel = 4'd2;
    lane_rx_on = 1'b1;
    tick();
    send_set(g3(TS1_BASE, 8'd0), g3(TS1_BASE, 8'd1));
    check("t1_not_yet_locked", 32'(os_locked), 32'h0);
    send_set(g3(TS1_BASE, 8'd0), g3(TS1_BASE, 8'd1));
    os_q.push_back('{edge_n + 1, 2'b11, 8'h22});
    send_set(g3(TS1_BASE, 8'd0), g3(TS1_BASE, 8'd1));
    check("t1_locked", 32'(os_locked), 32'h3);
    check("t1_os_in", 32'(os_in), 32'h22);
    go_off();

    // Lane 1 carries lane id 0: only lane 0 locks.
    lane_rx_on = 1'b1;
    tick();
    send_set(g3(TS1_BASE, 8'd0), g3(TS1_BASE, 8'd0));
    send_set(g3(TS1_BASE, 8'd0), g3(TS1_BASE, 8'd0));
    os_q.push_back('{edge_n + 1, 2'b01, 8'h92});
    send_set(g3(TS1_BASE, 8'd0), g3(TS1_BASE, 8'd0));
    check("t2_locked", 32'(os_locked), 32'h1);
    check("t2_os_in", 32'(os_in), 32'h92);
    go_off();

    // Gen4 TS2: good, corrupted, good, good. Upper word is don't-care.
    good  = {32'hDEAD_BEEF, G4_TS2};
    good2 = {32'h0123_4567, G4_TS2};
    bad   = {32'hDEAD_BEEF, G4_TS2 ^ 32'h0000_0100};
    d_sel = 4'd5;
    lane_rx_on = 1'b1;
    tick();
    send_set(good, good);
    send_set(bad, bad);
    send_set(good, good);
    check("t3_not_locked", 32'(os_locked), 32'h0);
    send_set(good2, good2);
    os_q.push_back('{edge_n + 1, 2'b11, 8'h55});
    send_set(good, good2);
    check("t3_locked", 32'(os_locked), 32'h3);
    check("t3_os_in", 32'(os_in), 32'h55);

    // d_sel 5 -> 6 in the middle of a set.
    ts3 = {32'hCAFE_F00D, G4_TS3};
    for (int k = 7; k >= 0; k--) begin
      if (k == 3) d_sel = 4'd6;
      send_byte(ts3[8*k +: 8], ts3[8*k +: 8]);
      if (k == 3) begin
        check("t4_unlock", 32'(os_locked), 32'h0);
        check("t4_os_in_idle", 32'(os_in), 32'h99);
      end
    end
    send_set(ts3, ts3);
    os_q.push_back('{edge_n + 1, 2'b11, 8'h66});
    send_set(ts3, ts3);
    check("t4_locked", 32'(os_locked), 32'h3);
    check("t4_os_in", 32'(os_in), 32'h66);
    go_off();

    // Timeout after 64 cycles of hunting.
    d_sel = 4'd2;
    lane_rx_on = 1'b1;
    tick();
    for (int n = 0; n < 63; n++) send_byte(8'($urandom), 8'($urandom));
    check("t5_timeout_early", 32'(os_timeout), 32'h0);
    send_byte(8'($urandom), 8'($urandom));
    check("t5_timeout_set", 32'(os_timeout), 32'h3);
    lane_rx_on = 1'b0;
    tick();
    check("t5_timeout_off", 32'(os_timeout), 32'h3);
    lane_rx_on = 1'b1;
    tick();
    tick();
    check("t5_timeout_back_on", 32'(os_timeout), 32'h3);
    d_sel = 4'd3;
    tick();
    check("t5_timeout_cleared", 32'(os_timeout), 32'h0);

    // Data mode.
    d_sel = 4'd8;
    data_os = 1'b1;
    lane_rx = 16'hA55A;
    tr_q.push_back('{edge_n + 1, 16'hA55A});
    tick();
    lane_rx = 16'h1234;
    tr_q.push_back('{edge_n + 1, 16'h1234});
    tick();
    data_os = 1'b0;
    lane_rx = 16'h7777;
    tick();
    check("t6_tvalid_low", 32'(transport_valid), 32'h0);
    check("t6_tdata_unqual", 32'(transport_data), 32'h7777);
    check("t6_hunt_locked", 32'(os_locked), 32'h0);
    data_os = 1'b1;
    lane_rx = 16'hBEEF;
    tr_q.push_back('{edge_n + 1, 16'hBEEF});
    tick();
    d_sel = 4'd2;
    tick();
    check("t6_exit_tvalid", 32'(transport_valid), 32'h0);
    check("t6_exit_tdata", 32'(transport_data), 32'h0);
    d_sel = 4'd8;
    lane_rx = 16'h5AA5;
    tr_q.push_back('{edge_n + 1, 16'h5AA5});
    tick();
    check("t6_tvalid_high", 32'(transport_valid), 32'h1);
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("t6_rst_tvalid", 32'(transport_valid), 32'h0);
    check("t6_rst_tdata", 32'(transport_data), 32'h0);
    check("t6_rst_os_in", 32'(os_in), 32'h99);
    check("t6_rst_locked", 32'(os_locked), 32'h0);
    check("t6_rst_timeout", 32'(os_timeout), 32'h0);
    tick();
    rst = 1'b1;
    lane_rx_on = 1'b0;
    tick();
    tick();

    check("os_queue_drained", os_q.size(), 0);
    check("tr_queue_drained", tr_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
